// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        StallEnable  = 1'b1;
    localparam int          InstAddrW    = 32;
    localparam int          InstW        = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [31:0] InstAddrIncr = 32'h0000_0004;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DROP  = 2'd2
    } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, runs the req/ack instruction-bus handshake and holds
// one fetched instruction for IF/ID; redirects on ID branches and flushes.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        stallreq_o,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_valid_q, out_valid_d;

    logic        freeze;
    logic        consume;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        stall_unused;

    assign freeze       = (stall[0] == StallEnable);
    assign consume      = !freeze && out_valid_q;
    assign stall_unused = ^stall[5:1];

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= ZeroWord;
            out_pc_q    <= ZeroWord;
            out_inst_q  <= ZeroWord;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        fetch_req   = 1'b0;
        fetch_addr  = pc_q;

        case (state_q)
            IF_IDLE: begin
                state_d = IF_FETCH;
            end

            IF_FETCH: begin
                // Only request when the output slot is free or drains this edge.
                fetch_req = !out_valid_q || !freeze;
                if (flush || (branch_flag_i && !freeze)) begin
                    pc_d        = flush ? new_pc : branch_target_i;
                    out_valid_d = 1'b0;
                    // An unacked request must be completed, so remember its address.
                    if (fetch_req && !ibus_ack_i) begin
                        drop_addr_d = pc_q;
                        state_d     = IF_DROP;
                    end
                end else if (fetch_req && ibus_ack_i) begin
                    out_pc_d    = pc_q;
                    out_inst_d  = ibus_rdata_i;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + InstAddrIncr;
                end else if (consume) begin
                    out_valid_d = 1'b0;
                end
            end

            IF_DROP: begin
                fetch_req  = 1'b1;
                fetch_addr = drop_addr_q;
                if (flush) begin
                    pc_d = new_pc;
                end else if (ibus_ack_i) begin
                    state_d = IF_FETCH;
                end
            end

            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    assign ibus_req_o  = fetch_req;
    assign ibus_addr_o = fetch_addr;
    assign stallreq_o  = !out_valid_q;
    assign if_pc       = out_valid_q ? out_pc_q   : ZeroWord;
    assign if_inst     = out_valid_q ? out_inst_q : ZeroWord;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle table, directed branch/flush sequences and a
// randomized run scored against the expected instruction stream.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic        stallreq_o;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory model: the word at an address is a fixed function of it.
    assign ibus_rdata_i = mk_inst(ibus_addr_o);

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
        .ibus_ack_i(ibus_ack_i), .ibus_rdata_i(ibus_rdata_i),
        .stallreq_o(stallreq_o), .if_pc(if_pc), .if_inst(if_inst)
    );

    typedef struct {
        logic        rs, s0, ack;
        logic        req;
        logic [31:0] addr;
        logic        sreq;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic s0, input logic ack, input logic fl,
                        input logic [31:0] npc, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        rst = rs; stall = {5'b0, s0}; ibus_ack_i = ack; flush = fl;
        new_pc = npc; branch_flag_i = br; branch_target_i = tgt;
        #1;
    endtask

    task automatic expect_out(input string nm, input logic req, input logic [31:0] addr,
                              input logic sreq, input logic [31:0] pc);
        chk({nm, ".req"},  32'(ibus_req_o), 32'(req));
        chk({nm, ".addr"}, ibus_addr_o, addr);
        chk({nm, ".sreq"}, 32'(stallreq_o), 32'(sreq));
        chk({nm, ".pc"},   if_pc, sreq ? 32'h0 : pc);
        chk({nm, ".inst"}, if_inst, sreq ? 32'h0 : mk_inst(pc));
    endtask

    task automatic add(input logic rs, input logic s0, input logic ack, input logic req,
                       input logic [31:0] addr, input logic sreq, input logic [31:0] pc);
        vec_t v;
        v.rs = rs; v.s0 = s0; v.ack = ack; v.req = req; v.addr = addr; v.sreq = sreq; v.pc = pc;
        tbl.push_back(v);
    endtask

    // Reset, IDLE, then one zero-wait fetch of RESET_PC: afterwards the next
    // cycle presents pc 0 with the bus at 0x4.
    task automatic restart();
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        logic        s0, fl, br, ack, pend, prev_pend;
        logic [31:0] npc, tgt, exp_pc, prev_addr;
        int          wl, idle;

        rst = 0; stall = 6'h3F; flush = 0; new_pc = 0; branch_flag_i = 0;
        branch_target_i = 0; ibus_ack_i = 1;

        step(0, 1, 1, 0, 0, 0, 0);
        expect_out("reset", 0, 32'h0, 1, 32'h0);

        //   rs s0 ack  req addr        sreq pc
        add(1, 1, 0,   0, 32'h00,     1,   32'h00);  // IDLE
        add(1, 1, 1,   1, 32'h00,     1,   32'h00);
        add(1, 0, 1,   1, 32'h04,     0,   32'h00);
        add(1, 0, 1,   1, 32'h08,     0,   32'h04);
        add(1, 0, 0,   1, 32'h0C,     0,   32'h08);
        add(1, 1, 0,   1, 32'h0C,     1,   32'h00);
        add(1, 1, 0,   1, 32'h0C,     1,   32'h00);
        add(1, 1, 1,   1, 32'h0C,     1,   32'h00);
        add(1, 1, 0,   0, 32'h10,     0,   32'h0C);  // external freeze
        add(1, 1, 1,   0, 32'h10,     0,   32'h0C);  // ack ignored, no req
        add(1, 0, 1,   1, 32'h10,     0,   32'h0C);
        add(1, 0, 0,   1, 32'h14,     0,   32'h10);
        add(0, 0, 0,   0, 32'h00,     1,   32'h00);  // async reset mid-wait
        add(1, 1, 0,   0, 32'h00,     1,   32'h00);
        add(1, 1, 0,   1, 32'h00,     1,   32'h00);
        add(1, 1, 1,   1, 32'h00,     1,   32'h00);
        add(1, 0, 0,   1, 32'h04,     0,   32'h00);
        add(1, 1, 0,   1, 32'h04,     1,   32'h00);  // 3 wait states on 0x4
        add(1, 1, 0,   1, 32'h04,     1,   32'h00);
        add(1, 1, 1,   1, 32'h04,     1,   32'h00);
        add(1, 1, 0,   0, 32'h08,     0,   32'h04);

        foreach (tbl[i]) begin
            step(tbl[i].rs, tbl[i].s0, tbl[i].ack, 0, 0, 0, 0);
            expect_out($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].sreq, tbl[i].pc);
        end

        // Taken branch at a consume edge with the sequential word acked.
        restart();
        step(1, 0, 1, 0, 0, 1, 32'h100);
        expect_out("br.edge", 1, 32'h04, 0, 32'h00);
        step(1, 1, 1, 0, 0, 0, 0);
        expect_out("br.bubble", 1, 32'h100, 1, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0);
        expect_out("br.target", 0, 32'h104, 0, 32'h100);

        // Flush while 0x8 is outstanding: complete it, discard, then go to 0x180.
        restart();
        step(1, 0, 1, 0, 0, 0, 0);
        expect_out("fl.c0", 1, 32'h04, 0, 32'h00);
        step(1, 0, 0, 0, 0, 0, 0);
        expect_out("fl.c4", 1, 32'h08, 0, 32'h04);
        step(1, 1, 0, 1, 32'h180, 0, 0);
        expect_out("fl.edge", 1, 32'h08, 1, 32'h0);
        step(1, 0, 0, 0, 0, 1, 32'h200);
        expect_out("drop.hold", 1, 32'h08, 1, 32'h0);
        step(1, 1, 1, 0, 0, 0, 0);
        expect_out("drop.ack", 1, 32'h08, 1, 32'h0);
        step(1, 1, 1, 0, 0, 0, 0);
        expect_out("fl.target", 1, 32'h180, 1, 32'h0);
        step(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        expect_out("fl.ackedge", 1, 32'h184, 0, 32'h180);
        step(1, 1, 1, 0, 0, 0, 0);
        expect_out("wrap.req", 1, 32'hFFFF_FFFC, 1, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0);
        expect_out("wrap.pc", 0, 32'h0, 0, 32'hFFFF_FFFC);

        // Randomized run: the consumed stream must follow the program order
        // implied by branches and flushes, and the bus must never drop a request.
        restart();
        exp_pc = 0; idle = 0; pend = 0; prev_pend = 0; prev_addr = 0; wl = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            s0  = stallreq_o | ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            br  = !fl && !s0 && ($urandom_range(0, 7) == 0);
            npc = $urandom & 32'hFFFF_FFFC;
            tgt = $urandom & 32'hFFFF_FFFC;
            rst = 1; stall = {5'($urandom), s0}; flush = fl; new_pc = npc;
            branch_flag_i = br; branch_target_i = tgt;
            #1;
            if (prev_pend) begin
                chk("bus.hold.req", 32'(ibus_req_o), 32'h1);
                chk("bus.hold.addr", ibus_addr_o, prev_addr);
            end
            if (ibus_req_o) begin
                if (!pend) begin
                    pend = 1;
                    wl   = $urandom_range(0, 3);
                end
                ack = (wl == 0);
                if (wl == 0) pend = 0;
                else         wl--;
            end else begin
                ack = 1'($urandom_range(0, 1));
            end
            ibus_ack_i = ack;
            prev_pend  = ibus_req_o && !ack;
            prev_addr  = ibus_addr_o;

            if (stallreq_o) begin
                chk("rnd.bubble.pc", if_pc, 32'h0);
                chk("rnd.bubble.inst", if_inst, 32'h0);
            end
            if (fl) begin
                exp_pc = npc;
                idle   = 0;
            end else if (!s0 && !stallreq_o) begin
                chk("rnd.pc", if_pc, exp_pc);
                chk("rnd.inst", if_inst, mk_inst(exp_pc));
                exp_pc = br ? tgt : exp_pc + 32'h4;
                idle   = 0;
            end else begin
                idle++;
                if (idle > 60) begin
                    total++; bad++;
                    $display("FAIL rnd.progress: no instruction for %0d cycles, want <= 60", idle);
                    break;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage for the five-stage pipeline. It owns the program counter and issues word requests on the instruction bus under a req/ack handshake. It holds one fetched instruction in an output register that feeds the IF/ID pipeline register, and it redirects on ID-stage branches and on pipeline flushes. It raises a stall request to the pipeline controller whenever it has no valid instruction to hand on.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  6  controller stall vector; only stall[0] (freeze IF) is used
- flush  in  1  exception flush; highest priority
- new_pc  in  32  flush target
- branch_flag_i  in  1  ID-stage taken branch/jump
- branch_target_i  in  32  branch target
- ibus_req_o  out  1  fetch request
- ibus_addr_o  out  32  fetch address; stable while req && !ack
- ibus_ack_i  in  1  data valid, sampled only while ibus_req_o=1
- ibus_rdata_i  in  32  instruction word
- stallreq_o  out  1  no valid instruction available
- if_pc  out  32  PC of the presented instruction, 0 when invalid
- if_inst  out  32  presented instruction, 0 (nop) when invalid

## Operation
- Registers: pc (next/in-flight address), drop_addr, out_pc, out_inst, out_valid, state ∈ {IDLE, FETCH, DROP}.
- Reset values: pc=RESET_PC, out_valid=0, out_pc=0, out_inst=0, state=IDLE. Outputs during reset: ibus_req_o=0, ibus_addr_o=RESET_PC, stallreq_o=1, if_pc=0, if_inst=0.
- Consume event: a clock edge with stall[0]=0 and out_valid=1. IF/ID takes if_pc/if_inst at this edge.
- IDLE: goes to FETCH on the first edge after reset is released. No request is issued in IDLE.
- FETCH outputs: ibus_req_o = !out_valid || !stall[0]. ibus_addr_o = pc.
- FETCH edge rules, in priority order:
  - flush: pc←new_pc, out_valid←0. Next state is DROP if req && !ack (drop_addr←pc), else FETCH. Any data acked at this edge is discarded.
  - branch_flag_i && !stall[0]: same as flush, but with branch_target_i. The delay-slot instruction is consumed at this edge.
  - req && ack: out_pc←pc, out_inst←ibus_rdata_i, out_valid←1, pc←pc+4. This is legal at the same edge as a consume.
  - consume without ack: out_valid←0.
- DROP outputs: ibus_req_o=1, ibus_addr_o=drop_addr.
- DROP edge rules:
  - ack: data discarded, next state FETCH.
  - flush: pc←new_pc, state stays DROP. This also applies when flush and ack occur at the same edge.
  - branch_flag_i is ignored.
- stallreq_o = !out_valid, driven from a register only, so there is no combinational loop through the controller.
- if_pc = out_valid ? out_pc : 0. if_inst = out_valid ? out_inst : 0.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Addresses pass through unmodified; alignment checks belong to the exception logic.
- The bus never sees an abandoned request except on reset.

## Timing
- After reset release: IDLE for 1 cycle, first req in cycle 2.
- Zero-wait bus: req/ack in cycle n, valid if_inst in n+1. Sustained rate is 1 instruction per cycle.
- Each wait state adds one cycle with stallreq_o=1.
- Taken branch or flush: at least one bubble cycle (out_valid=0). DROP adds the remaining latency of the stale access.
- Async reset mid-access: all outputs reach reset values without a clock edge.

## Structure
- Add to defines.v:
  - a reset-active-low constant for this block
  - `IfStateBus (2 bits) with encodings `IfIdle/`IfFetch/`IfDrop
  - `InstAddrIncr (32'h4)
- Reuse `InstAddrBus, `InstBus, `ZeroWord and `StallEnable.
- No sub-module: a single module holding the FSM, the PC and the output register.

## Test plan
- Reset release, ack held 1, controller model closing the stallreq→stall[0] loop → if_pc = 0x0, 0x4, 0x8 on consecutive cycles after the first bubble.
- ack delayed 3 cycles on 0x4 → ibus_addr_o held at 0x4, stallreq_o=1 for 3 cycles, then if_inst equals the rdata for 0x4.
- Branch at a consume edge with target 0x100 and ack in the same cycle → the acked word is dropped, the next req is at 0x100, and one bubble appears.
- flush with new_pc=0x180 while a req to 0x8 is unacked → DROP holds addr 0x8 until ack, the data is discarded, then req at 0x180.
- External stall[0]=1 while out_valid=1 → req low and outputs stable. On release, consumed in 1 cycle and fetch resumes.
- Assert rst=0 mid-wait → req=0, if_inst=0, stallreq_o=1 immediately. After release, the fetch restarts at RESET_PC.
